// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Decode-stage hazard and stall controller for the 5-stage RISC-V pipeline.
// Handles the hazards the EX forwarding unit cannot cover:
//   - load-use against the load currently in EX,
//   - RAW/WAW against the single in-flight multi-cycle multiply,
//   - structural conflict on the multiplier itself,
//   - taken-branch flush, which overrides every hazard.
// It also owns the multiplier occupancy tracker (busy, rd, latency counter) and
// pulses mul_done in the writeback cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   IF_ID_*           decode-stage instruction (valid, rs1, rs2, rd, regwr, is_mul)
//   ID_EX_memread/rd  load-in-EX indication and its destination
//   ex_branch_taken   branch/jump in EX redirects the PC this cycle
//   pc_stall          hold PC and IF_ID
//   ID_EX_bubble      load a NOP into ID_EX
//   IF_ID_flush       load a NOP into IF_ID
//   mul_busy/mul_rd   multiplier occupancy and destination of in-flight multiply
//   mul_done          one-cycle pulse in the multiply writeback cycle
//   stall_cycles      saturating count of cycles with pc_stall asserted
//
// Multiplier occupancy sequencing:
//   StIdle -> StRun on issue with counter = MUL_LAT-1, counter decrements in
//   StRun, StDone is the counter==0 cycle. A multiply may issue in StDone, in
//   which case the new multiply's load wins and the tracker goes straight back
//   to StRun. mul_busy is therefore high for exactly MUL_LAT cycles per issue.
module hazard_scoreboard #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_ID_valid,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       IF_ID_rd,
  input  logic             IF_ID_regwr,
  input  logic             IF_ID_is_mul,
  input  logic             ID_EX_memread,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             mul_busy,
  output logic [4:0]       mul_rd,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // MUL_LAT >= 2, so $clog2(MUL_LAT) is at least 1 and always holds MUL_LAT-1.
  localparam int unsigned LatW = $clog2(MUL_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mul_state_e;

  mul_state_e       state_q, state_d;
  logic [LatW-1:0]  cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic busy;
  logic done;
  logic load_use;
  logic mul_raw;
  logic mul_waw;
  logic mul_str;
  logic hazard;
  logic issue;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Hazard detection. x0 never creates a dependency. The RAW/WAW terms stay
  // active through the mul_done cycle: there is no same-cycle bypass from the
  // multiplier writeback, so dependent decode proceeds the cycle after.
  always_comb begin
    load_use = 1'b0;
    mul_raw  = 1'b0;
    mul_waw  = 1'b0;
    mul_str  = 1'b0;
    if (IF_ID_valid) begin
      load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                 ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
      mul_raw  = busy && (rd_q != 5'd0) &&
                 ((rd_q == IF_ID_rs1) || (rd_q == IF_ID_rs2));
      mul_waw  = busy && IF_ID_regwr && (IF_ID_rd != 5'd0) && (IF_ID_rd == rd_q);
      // A new multiply may enter only in the writeback cycle of the old one.
      mul_str  = busy && IF_ID_is_mul && !done;
    end
    hazard = load_use || mul_raw || mul_waw || mul_str;
  end

  // Pipeline control: a taken branch squashes decode, so it wins over stalls.
  always_comb begin
    pc_stall     = 1'b0;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (ex_branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (hazard) begin
      pc_stall     = 1'b1;
      ID_EX_bubble = 1'b1;
    end
  end

  assign issue = IF_ID_valid && IF_ID_is_mul && !pc_stall && !ex_branch_taken;

  // Multiplier occupancy tracker. A branch never kills an in-flight multiply:
  // it entered EX ahead of the branch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
      end
      StRun: begin
        cnt_d = cnt_q - LatW'(1);
        if (cnt_q == LatW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (issue) begin
      state_d = StRun;
      cnt_d   = LatW'(MUL_LAT - 1);
      rd_d    = IF_ID_rd;
    end
  end

  // Performance counter saturates rather than wrapping.
  always_comb begin
    stall_d = stall_q;
    if (pc_stall && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

  assign mul_busy     = busy;
  assign mul_rd       = rd_q;
  assign mul_done     = done;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int unsigned MulLat = 4;
  localparam int unsigned CntW   = 3;  // narrow so saturation is reachable

  logic            clk;
  logic            rst;
  logic            IF_ID_valid;
  logic [4:0]      IF_ID_rs1;
  logic [4:0]      IF_ID_rs2;
  logic [4:0]      IF_ID_rd;
  logic            IF_ID_regwr;
  logic            IF_ID_is_mul;
  logic            ID_EX_memread;
  logic [4:0]      ID_EX_rd;
  logic            ex_branch_taken;
  logic            pc_stall;
  logic            ID_EX_bubble;
  logic            IF_ID_flush;
  logic            mul_busy;
  logic [4:0]      mul_rd;
  logic            mul_done;
  logic [CntW-1:0] stall_cycles;

  hazard_scoreboard #(
    .MUL_LAT(MulLat),
    .CNT_W  (CntW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_valid    (IF_ID_valid),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .IF_ID_rd       (IF_ID_rd),
    .IF_ID_regwr    (IF_ID_regwr),
    .IF_ID_is_mul   (IF_ID_is_mul),
    .ID_EX_memread  (ID_EX_memread),
    .ID_EX_rd       (ID_EX_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_stall       (pc_stall),
    .ID_EX_bubble   (ID_EX_bubble),
    .IF_ID_flush    (IF_ID_flush),
    .mul_busy       (mul_busy),
    .mul_rd         (mul_rd),
    .mul_done       (mul_done),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwr;
    logic       is_mul;
    logic       memread;
    logic [4:0] ex_rd;
    logic       br;
    logic       e_stall;
    logic       e_bubble;
    logic       e_flush;
    logic       e_busy;
    logic [4:0] e_mrd;
    logic       e_done;
    logic       chk_rd;  // mul_rd is only defined while busy or after reset
  } vec_t;

  typedef struct {
    logic            stall;
    logic            bubble;
    logic            flush;
    logic            busy;
    logic [4:0]      mrd;
    logic            done;
    logic            chk_rd;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t            sb[$];
  logic [CntW-1:0] cnt_model;
  int              n_cmp;
  int              n_fail;
  vec_t            tbl[10];

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // Decode-only vector: no load in EX, no branch; a stall always bubbles.
  function automatic vec_t mkv(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic regwr, input logic is_mul,
                               input logic stall, input logic busy, input logic [4:0] mrd,
                               input logic done);
    vec_t v;
    v.rst = 1'b0;      v.valid = valid;   v.rs1 = rs1;       v.rs2 = rs2;
    v.rd = rd;         v.regwr = regwr;   v.is_mul = is_mul; v.memread = 1'b0;
    v.ex_rd = 5'd0;    v.br = 1'b0;       v.e_stall = stall; v.e_bubble = stall;
    v.e_flush = 1'b0;  v.e_busy = busy;   v.e_mrd = mrd;     v.e_done = done;
    v.chk_rd = busy;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rst             = v.rst;
    IF_ID_valid     = v.valid;
    IF_ID_rs1       = v.rs1;
    IF_ID_rs2       = v.rs2;
    IF_ID_rd        = v.rd;
    IF_ID_regwr     = v.regwr;
    IF_ID_is_mul    = v.is_mul;
    ID_EX_memread   = v.memread;
    ID_EX_rd        = v.ex_rd;
    ex_branch_taken = v.br;
    e.stall = v.e_stall;  e.bubble = v.e_bubble; e.flush = v.e_flush;
    e.busy = v.e_busy;    e.mrd = v.e_mrd;       e.done = v.e_done;
    e.chk_rd = v.chk_rd;  e.cnt = cnt_model;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(tag, "pc_stall", 32'(pc_stall), 32'(e.stall));
    chk(tag, "ID_EX_bubble", 32'(ID_EX_bubble), 32'(e.bubble));
    chk(tag, "IF_ID_flush", 32'(IF_ID_flush), 32'(e.flush));
    chk(tag, "mul_busy", 32'(mul_busy), 32'(e.busy));
    chk(tag, "mul_done", 32'(mul_done), 32'(e.done));
    if (e.chk_rd) chk(tag, "mul_rd", 32'(mul_rd), 32'(e.mrd));
    chk(tag, "stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    @(posedge clk);
    #1;
    if (v.rst) cnt_model = '0;
    else if (v.e_stall && (cnt_model != '1)) cnt_model = cnt_model + 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_cmp     = 0;
    n_fail    = 0;
    cnt_model = '0;

    //         rst v rs1 rs2 rd wr mul mr exrd br  stl bub fl  bsy mrd dn chk
    tbl[0] = '{0, 0, 0,  0,  0, 0, 0,  0, 0,   0,  0,  0,  0,  0,  0,  0, 1};  // reset state
    tbl[1] = '{0, 1, 5,  1,  6, 1, 0,  1, 5,   0,  1,  1,  0,  0,  0,  0, 1};  // lw x5; add x6,x5,x1
    tbl[2] = '{0, 1, 5,  1,  6, 1, 0,  0, 0,   0,  0,  0,  0,  0,  0,  0, 1};  // bubble in EX, proceed
    tbl[3] = '{0, 1, 2,  5,  6, 1, 0,  1, 5,   0,  1,  1,  0,  0,  0,  0, 1};  // rs2 match
    tbl[4] = '{0, 1, 0,  0,  6, 1, 0,  1, 0,   0,  0,  0,  0,  0,  0,  0, 1};  // x0 load never matches
    tbl[5] = '{0, 1, 1,  2,  6, 1, 0,  1, 5,   0,  0,  0,  0,  0,  0,  0, 1};  // unrelated regs
    tbl[6] = '{0, 0, 5,  5,  6, 1, 0,  1, 5,   0,  0,  0,  0,  0,  0,  0, 1};  // invalid decode
    tbl[7] = '{0, 1, 5,  1,  6, 1, 0,  1, 5,   1,  0,  1,  1,  0,  0,  0, 1};  // load-use + branch
    tbl[8] = '{0, 1, 1,  2,  6, 1, 0,  0, 0,   1,  0,  1,  1,  0,  0,  0, 1};  // branch only
    tbl[9] = '{0, 0, 0,  0,  0, 0, 0,  0, 0,   1,  0,  1,  1,  0,  0,  0, 1};  // branch, empty decode

    rst = 1'b1;
    IF_ID_valid = 1'b0; IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_rd = '0;
    IF_ID_regwr = 1'b0; IF_ID_is_mul = 1'b0; ID_EX_memread = 1'b0; ID_EX_rd = '0;
    ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // mul x7 then sub x8,x7,x2: stalled while busy, including the done cycle.
    step(mkv(1, 1, 2, 7, 1, 1, 0, 0, 0, 0), "raw_c0");
    for (int c = 1; c <= 4; c++)
      step(mkv(1, 7, 2, 8, 1, 0, 1, 1, 7, c == 4), $sformatf("raw_c%0d", c));
    step(mkv(1, 7, 2, 8, 1, 0, 0, 0, 0, 0), "raw_c5");

    // WAW on x7 stalls; an independent add slips through while busy.
    step(mkv(1, 1, 2, 7, 1, 1, 0, 0, 0, 0), "waw_c0");
    step(mkv(1, 1, 2, 9, 1, 0, 0, 1, 7, 0), "waw_c1");
    for (int c = 2; c <= 4; c++)
      step(mkv(1, 0, 0, 7, 1, 0, 1, 1, 7, c == 4), $sformatf("waw_c%0d", c));
    step(mkv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0), "waw_c5");

    // Back-to-back multiplies: issue allowed only in the done cycle.
    step(mkv(1, 1, 2, 3, 1, 1, 0, 0, 0, 0), "b2b_c0");
    for (int c = 1; c <= 3; c++)
      step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 3, 0), $sformatf("b2b_c%0d", c));
    step(mkv(1, 1, 2, 4, 1, 1, 0, 1, 3, 1), "b2b_c4");
    for (int c = 5; c <= 7; c++)
      step(mkv(1, 1, 2, 10, 1, 1, 1, 1, 4, 0), $sformatf("b2b_c%0d", c));
    step(mkv(1, 1, 2, 10, 1, 1, 0, 1, 4, 1), "b2b_c8");
    for (int c = 9; c <= 12; c++)
      step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 10, c == 12), $sformatf("b2b_c%0d", c));
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "b2b_c13");

    // Reset two cycles after issue abandons the multiply without a done pulse.
    step(mkv(1, 1, 2, 7, 1, 1, 0, 0, 0, 0), "rst_c0");
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0), "rst_c1");
    v = mkv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    v.rst = 1'b1;
    step(v, "rst_c2");
    for (int c = 3; c <= 5; c++) begin
      v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.chk_rd = 1'b1;
      step(v, $sformatf("rst_c%0d", c));
    end

    // Load into x0 with x0 sources: no stall.
    v = mkv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    v.memread = 1'b1;
    v.chk_rd = 1'b1;
    step(v, "x0_load");

    // Multiply into x0: later x0 readers/writers never match it.
    v = mkv(1, 1, 2, 0, 1, 1, 0, 0, 0, 0);
    v.chk_rd = 1'b1;
    step(v, "x0mul_c0");
    step(mkv(1, 0, 0, 0, 1, 0, 0, 1, 0, 0), "x0mul_c1");
    step(mkv(1, 1, 2, 5, 1, 1, 1, 1, 0, 0), "x0mul_c2");
    step(mkv(1, 1, 2, 5, 1, 1, 1, 1, 0, 0), "x0mul_c3");
    step(mkv(1, 1, 2, 5, 1, 1, 0, 1, 0, 1), "x0mul_c4");
    for (int c = 5; c <= 8; c++)
      step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 5, c == 8), $sformatf("x0mul_c%0d", c));
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "x0mul_c9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
